// File: rtl/data_sram_responder_if.sv
// Data-SRAM request/response bundle between the memory stage
// (master) and the data memory model (slave).
interface data_sram_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        stall_in;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        data_sram_err;

    modport master (
        output data_sram_req,
        output data_sram_wr,
        output data_sram_size,
        output data_sram_wstrb,
        output data_sram_addr,
        output data_sram_wdata,
        output stall_in,
        input  data_sram_addr_ok,
        input  data_sram_data_ok,
        input  data_sram_rdata,
        input  data_sram_err
    );

    modport slave (
        input  data_sram_req,
        input  data_sram_wr,
        input  data_sram_size,
        input  data_sram_wstrb,
        input  data_sram_addr,
        input  data_sram_wdata,
        input  stall_in,
        output data_sram_addr_ok,
        output data_sram_data_ok,
        output data_sram_rdata,
        output data_sram_err
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-organised data memory behind a req/addr_ok/data_ok handshake,
// in-order responses with fixed latency and bounded outstanding count.
module data_sram_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input logic                 clk,
    input logic                 resetn,
    data_sram_responder_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]       r_mem [2**ADDR_W];
    logic [1:0]        r_rst_sync;
    logic [CW-1:0]     r_count;
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_err;
    logic [31:0]       r_dat [LATENCY];

    logic              w_run;
    logic              w_addr_ok;
    logic              w_accept;
    logic              w_dok;
    logic              w_mis;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rd;
    logic              w_unused;

    // addr_ok stays low until reset release has passed two flops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run     = r_rst_sync[1];
    assign w_addr_ok = w_run && !bus.stall_in && (r_count < CW'(DEPTH));
    assign w_accept  = bus.data_sram_req && w_addr_ok;
    assign w_dok     = r_vld[LATENCY-1];
    assign w_idx     = bus.data_sram_addr[ADDR_W+1:2];
    assign w_unused  = ^bus.data_sram_addr[31:ADDR_W+2];

    always_comb begin
        w_mis = 1'b0;
        unique case (bus.data_sram_size)
            2'd0: w_mis = 1'b0;
            2'd1: w_mis = bus.data_sram_addr[0];
            2'd2: w_mis = (bus.data_sram_addr[1:0] != 2'b00);
            2'd3: w_mis = 1'b1;
        endcase
    end

    assign w_rd = (bus.data_sram_wr || w_mis) ? 32'h0 : r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (w_accept && bus.data_sram_wr && !w_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Final stage doubles as the port register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld <= '0;
            r_err <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            r_err[0] <= w_accept && w_mis;
            r_dat[0] <= w_accept ? w_rd : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else begin
            unique case ({w_accept, w_dok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.data_sram_addr_ok = w_addr_ok;
    assign bus.data_sram_data_ok = w_dok;
    assign bus.data_sram_rdata   = r_dat[LATENCY-1];
    assign bus.data_sram_err     = r_err[LATENCY-1];
endmodule
